// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: forwarding
// select encodings, the divider-tracker state type, and a register-number
// match helper that never matches $0.
package mips_pkg;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // True when destination dst is a real register that equals source src.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/div_tracker.sv
// Tracks the multi-cycle divider. A start in IDLE or DONE loads the counter
// with DIV_CYCLES-2; BUSY counts down to zero, then one DONE cycle follows.
// busy_o is registered and covers exactly DIV_CYCLES cycles after the start
// edge. state_o exposes the FSM state for observation.
module div_tracker
  import mips_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_div_i,
  output logic       busy_o,
  output div_state_e state_o
);

  localparam logic [5:0] CNT_LOAD = 6'(DIV_CYCLES - 2);

  div_state_e state_q;
  logic [5:0] cnt_q;
  logic       busy_q;

  // Divider FSM with counter and registered busy flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_div_i) begin
            state_q <= BUSY;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
          end
        end
        BUSY: begin
          // A start here cannot happen: HI/LO users are stalled in decode.
          if (cnt_q != 6'd0) begin
            cnt_q <= cnt_q - 6'd1;
          end else begin
            state_q <= DONE;
          end
          busy_q <= 1'b1;
        end
        DONE: begin
          if (start_div_i) begin
            state_q <= BUSY;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 6'd0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign state_o = state_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline.
// Stall, flush and forward outputs are combinational; only the divider
// tracker holds state. While rst_n is low the outputs are forced to a safe
// idle pattern (FlushE=1, everything else 0).
// Optional: define HAZ_PERF_CNT_EN to add stall_cnt, flush_cnt and
// div_stall_cnt performance counters of width CNT_W.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int DIV_CYCLES = 32
`ifdef HAZ_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemToRegE,
  input  logic       MemToRegM,
  input  logic       BranchD,
  input  logic       PCSrcD,
  input  logic       hilo_use_D,
  input  logic       start_div_E,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       div_busy
`ifdef HAZ_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
  , output logic [CNT_W-1:0] div_stall_cnt
`endif
);

  logic       div_busy_raw;
  div_state_e div_state;
  logic       lwstall, brstall, divstall, stall, flush_d;
  logic [1:0] fwd_ae, fwd_be;

  div_tracker #(.DIV_CYCLES(DIV_CYCLES)) u_div_tracker (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_div_i (start_div_E),
    .busy_o      (div_busy_raw),
    .state_o     (div_state)
  );

  // The registered busy flag must always agree with the tracker state.
  busy_matches_state: assert property (@(posedge clk)
    div_busy_raw == (div_state != IDLE));

  // Hazard detection: causes are ORed into one stall.
  always_comb begin
    lwstall  = MemToRegE & RegWriteE &
               (reg_match(WriteRegE, RsD) | reg_match(WriteRegE, RtD));
    brstall  = BranchD &
               ((RegWriteE & (reg_match(WriteRegE, RsD) | reg_match(WriteRegE, RtD))) |
                (MemToRegM & (reg_match(WriteRegM, RsD) | reg_match(WriteRegM, RtD))));
    divstall = div_busy_raw & hilo_use_D;
    stall    = lwstall | brstall | divstall;
    // A taken branch that is itself stalled re-evaluates next cycle.
    flush_d  = PCSrcD & ~stall;
  end

  // Execute forwarding: the younger M-stage result wins over W.
  always_comb begin
    fwd_ae = FWD_RF;
    fwd_be = FWD_RF;
    if (RegWriteM & reg_match(WriteRegM, RsE))      fwd_ae = FWD_M;
    else if (RegWriteW & reg_match(WriteRegW, RsE)) fwd_ae = FWD_W;
    if (RegWriteM & reg_match(WriteRegM, RtE))      fwd_be = FWD_M;
    else if (RegWriteW & reg_match(WriteRegW, RtE)) fwd_be = FWD_W;
  end

  // Output drive, forced to the idle pattern while reset is held.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b1;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    div_busy  = 1'b0;
    if (rst_n) begin
      StallF    = stall;
      StallD    = stall;
      FlushD    = flush_d;
      FlushE    = stall;
      ForwardAD = RegWriteM & reg_match(WriteRegM, RsD);
      ForwardBD = RegWriteM & reg_match(WriteRegM, RtD);
      ForwardAE = fwd_ae;
      ForwardBE = fwd_be;
      div_busy  = div_busy_raw;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, div_stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d, flush_cnt_d, div_stall_cnt_d;

  // Next counter values; wrap naturally modulo 2^CNT_W.
  always_comb begin
    stall_cnt_d     = stall    ? stall_cnt_q + CNT_ONE     : stall_cnt_q;
    flush_cnt_d     = flush_d  ? flush_cnt_q + CNT_ONE     : flush_cnt_q;
    div_stall_cnt_d = divstall ? div_stall_cnt_q + CNT_ONE : div_stall_cnt_q;
  end

  // Performance counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q     <= '0;
      flush_cnt_q     <= '0;
      div_stall_cnt_q <= '0;
    end else begin
      stall_cnt_q     <= stall_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
      div_stall_cnt_q <= div_stall_cnt_d;
    end
  end

  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;
  assign div_stall_cnt = div_stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a table of single-cycle vectors for the
// combinational hazard/forward logic, plus hand-written sequences for the
// divider stall window and reset during a divide.
module tb_hazard_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM;
  logic BranchD, PCSrcD, hilo_use_D, start_div_E;
  logic StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, div_busy;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, div_stall_cnt;
`endif

  hazard_ctrl #(.DIV_CYCLES(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RsD         (RsD),
    .RtD         (RtD),
    .RsE         (RsE),
    .RtE         (RtE),
    .WriteRegE   (WriteRegE),
    .WriteRegM   (WriteRegM),
    .WriteRegW   (WriteRegW),
    .RegWriteE   (RegWriteE),
    .RegWriteM   (RegWriteM),
    .RegWriteW   (RegWriteW),
    .MemToRegE   (MemToRegE),
    .MemToRegM   (MemToRegM),
    .BranchD     (BranchD),
    .PCSrcD      (PCSrcD),
    .hilo_use_D  (hilo_use_D),
    .start_div_E (start_div_E),
    .StallF      (StallF),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .ForwardAD   (ForwardAD),
    .ForwardBD   (ForwardBD),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .div_busy    (div_busy)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt     (stall_cnt)
    , .flush_cnt     (flush_cnt)
    , .div_stall_cnt (div_stall_cnt)
`endif
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
    logic       rw_e, rw_m, rw_w, m2r_e, m2r_m, br_d, pc_d;
    logic       stall, flush_d, fwd_ad, fwd_bd;
    logic [1:0] fwd_ae, fwd_be;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  function automatic vec_t mk(
    input logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w,
    input logic rw_e, rw_m, rw_w, m2r_e, m2r_m, br_d, pc_d,
    input logic stall, flush_d, fwd_ad, fwd_bd,
    input logic [1:0] fwd_ae, fwd_be);
    vec_t v;
    v.rs_d = rs_d; v.rt_d = rt_d; v.rs_e = rs_e; v.rt_e = rt_e;
    v.wr_e = wr_e; v.wr_m = wr_m; v.wr_w = wr_w;
    v.rw_e = rw_e; v.rw_m = rw_m; v.rw_w = rw_w;
    v.m2r_e = m2r_e; v.m2r_m = m2r_m; v.br_d = br_d; v.pc_d = pc_d;
    v.stall = stall; v.flush_d = flush_d; v.fwd_ad = fwd_ad; v.fwd_bd = fwd_bd;
    v.fwd_ae = fwd_ae; v.fwd_be = fwd_be;
    return v;
  endfunction

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

`ifdef HAZ_PERF_CNT_EN
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
`endif

  // ---------------- driver tasks ----------------
  task automatic drive_vec(input vec_t v);
    RsD = v.rs_d; RtD = v.rt_d; RsE = v.rs_e; RtE = v.rt_e;
    WriteRegE = v.wr_e; WriteRegM = v.wr_m; WriteRegW = v.wr_w;
    RegWriteE = v.rw_e; RegWriteM = v.rw_m; RegWriteW = v.rw_w;
    MemToRegE = v.m2r_e; MemToRegM = v.m2r_m;
    BranchD = v.br_d; PCSrcD = v.pc_d;
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d", idx);
    check1({p, ".StallF"}, StallF, v.stall);
    check1({p, ".StallD"}, StallD, v.stall);
    check1({p, ".FlushE"}, FlushE, v.stall);
    check1({p, ".FlushD"}, FlushD, v.flush_d);
    check1({p, ".ForwardAD"}, ForwardAD, v.fwd_ad);
    check1({p, ".ForwardBD"}, ForwardBD, v.fwd_bd);
    check2({p, ".ForwardAE"}, ForwardAE, v.fwd_ae);
    check2({p, ".ForwardBE"}, ForwardBE, v.fwd_be);
    check1({p, ".div_busy"}, div_busy, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main test ----------------
  initial begin
    //             rsd rtd rse rte wre wrm wrw  rwe rwm rww m2e m2m br pc | st fd ad bd ae     be
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    vecs[1]  = mk(8, 1, 0, 0, 8, 0, 0,  1, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 2'b00, 2'b00);
    vecs[2]  = mk(2, 1, 8, 1, 0, 8, 0,  0, 1, 0, 0, 1, 0, 0,  0, 0, 0, 0, 2'b10, 2'b00);
    vecs[3]  = mk(1, 8, 0, 0, 8, 0, 0,  1, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 2'b00, 2'b00);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    vecs[5]  = mk(0, 0, 5, 0, 0, 5, 5,  0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 2'b10, 2'b00);
    vecs[6]  = mk(0, 0, 5, 0, 0, 5, 5,  0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 2'b01, 2'b00);
    vecs[7]  = mk(0, 0, 0, 0, 0, 5, 5,  0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    vecs[8]  = mk(0, 0, 0, 7, 0, 7, 7,  0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b01);
    vecs[9]  = mk(0, 0, 9, 7, 0, 7, 9,  0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 2'b01, 2'b10);
    vecs[10] = mk(3, 0, 0, 0, 3, 0, 0,  1, 0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 2'b00, 2'b00);
    vecs[11] = mk(3, 0, 0, 0, 0, 3, 0,  0, 1, 0, 0, 0, 1, 0,  0, 0, 1, 0, 2'b00, 2'b00);
    vecs[12] = mk(3, 0, 0, 0, 0, 3, 0,  0, 1, 0, 0, 0, 1, 1,  0, 1, 1, 0, 2'b00, 2'b00);
    vecs[13] = mk(0, 4, 0, 0, 0, 4, 0,  0, 1, 0, 0, 1, 1, 1,  1, 0, 0, 1, 2'b00, 2'b00);
    vecs[14] = mk(0, 6, 0, 0, 6, 0, 0,  0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    vecs[15] = mk(9, 0, 0, 0, 9, 0, 0,  0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1, 1,  0, 1, 0, 0, 2'b00, 2'b00);
    vecs[17] = mk(4, 0, 0, 0, 0, 4, 0,  0, 1, 0, 0, 1, 0, 0,  0, 0, 1, 0, 2'b00, 2'b00);
    vecs[18] = mk(8, 0, 0, 0, 8, 0, 0,  1, 0, 0, 1, 0, 0, 1,  1, 0, 0, 0, 2'b00, 2'b00);

    // Reset with a load-use hazard and HI/LO use present: outputs forced.
    rst_n = 1'b0;
    start_div_E = 1'b0;
    hilo_use_D = 1'b1;
    drive_vec(vecs[9]);
    RsD = 5'd9; RegWriteM = 1'b1; WriteRegM = 5'd9;
    MemToRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd9;
    repeat (2) next_cycle();
    @(negedge clk);
    check1("rst.StallF", StallF, 1'b0);
    check1("rst.StallD", StallD, 1'b0);
    check1("rst.FlushD", FlushD, 1'b0);
    check1("rst.FlushE", FlushE, 1'b1);
    check1("rst.ForwardAD", ForwardAD, 1'b0);
    check2("rst.ForwardAE", ForwardAE, 2'b00);
    check2("rst.ForwardBE", ForwardBE, 2'b00);
    check1("rst.div_busy", div_busy, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    hilo_use_D = 1'b0;
    drive_vec(vecs[0]);

`ifdef HAZ_PERF_CNT_EN
    // Three load-use stalls then two taken branches.
    next_cycle();
    for (int k = 0; k < 3; k++) begin drive_vec(vecs[1]); next_cycle(); end
    for (int k = 0; k < 2; k++) begin drive_vec(vecs[12]); next_cycle(); end
    drive_vec(vecs[0]);
    @(negedge clk);
    check32("perf.stall_cnt", stall_cnt, 32'd3);
    check32("perf.flush_cnt", flush_cnt, 32'd2);
    check32("perf.div_stall_cnt", div_stall_cnt, 32'd0);
    next_cycle();
`endif

    // Table-driven combinational vectors, one per cycle.
    for (int i = 0; i < NV; i++) begin
      drive_vec(vecs[i]);
      @(negedge clk);
      check_vec(i, vecs[i]);
      next_cycle();
    end

    // Divide: start pulse, then HI/LO user held in decode.
    drive_vec(vecs[0]);
    hilo_use_D = 1'b1;
    start_div_E = 1'b1;
    @(negedge clk);
    check1("div.pre_busy", div_busy, 1'b0);
    check1("div.pre_stall", StallF, 1'b0);
    next_cycle();
    start_div_E = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check1($sformatf("div.c%0d.StallF", i), StallF, 1'b1);
      check1($sformatf("div.c%0d.busy", i), div_busy, 1'b1);
      if (i == 10) begin
        hilo_use_D = 1'b0;
        #1;
        check1("div.non_hilo.StallF", StallF, 1'b0);
        check1("div.non_hilo.FlushE", FlushE, 1'b0);
        check1("div.non_hilo.busy", div_busy, 1'b1);
        hilo_use_D = 1'b1;
      end
      next_cycle();
    end
    @(negedge clk);
    check1("div.after.StallF", StallF, 1'b0);
    check1("div.after.busy", div_busy, 1'b0);
    next_cycle();
    hilo_use_D = 1'b0;

    // Reset in the middle of a divide abandons it.
    start_div_E = 1'b1;
    next_cycle();
    start_div_E = 1'b0;
    repeat (10) next_cycle();
    @(negedge clk);
    check1("rstdiv.busy_before", div_busy, 1'b1);
    next_cycle();
    rst_n = 1'b0;
    hilo_use_D = 1'b1;
    @(negedge clk);
    check1("rstdiv.low.FlushE", FlushE, 1'b1);
    check1("rstdiv.low.StallF", StallF, 1'b0);
    check1("rstdiv.low.busy", div_busy, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check1("rstdiv.rel.busy", div_busy, 1'b0);
    check1("rstdiv.rel.StallF", StallF, 1'b0);
    check1("rstdiv.rel.FlushE", FlushE, 1'b0);
    next_cycle();
    @(negedge clk);
    check1("rstdiv.rel2.StallD", StallD, 1'b0);
    next_cycle();

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
